// File: rtl/flash_txn_if.sv
// flash_txn_if
//   Bundles the host request/response handshake and the spi_controller frame
//   fields used by flash_txn_sequencer.
//   slave  : sequencer side (takes requests and spi_done, drives frames and responses)
//   master : host + spi_controller side (the opposite directions)
// Signals
//   req_valid/req_ready/req_op/req_addr/req_len : host request
//   rsp_valid/rsp_err/busy                      : completion and status
//   spi_start/spi_opcode/spi_addr/spi_addr_en/
//   spi_nbytes/spi_rd                           : frame launch toward spi_controller
//   spi_done/spi_status                         : frame completion from spi_controller
interface flash_txn_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic        rsp_err;
  logic        busy;
  logic        spi_start;
  logic [7:0]  spi_opcode;
  logic [23:0] spi_addr;
  logic        spi_addr_en;
  logic [7:0]  spi_nbytes;
  logic        spi_rd;
  logic        spi_done;
  logic [7:0]  spi_status;

  modport slave (
    input  req_valid, req_op, req_addr, req_len, spi_done, spi_status,
    output req_ready, rsp_valid, rsp_err, busy,
           spi_start, spi_opcode, spi_addr, spi_addr_en, spi_nbytes, spi_rd
  );

  modport master (
    output req_valid, req_op, req_addr, req_len, spi_done, spi_status,
    input  req_ready, rsp_valid, rsp_err, busy,
           spi_start, spi_opcode, spi_addr, spi_addr_en, spi_nbytes, spi_rd
  );
endinterface

// File: rtl/flash_txn_sequencer.sv
// flash_txn_sequencer
//   Turns one host request (READ, PAGE_PROGRAM, SECTOR_ERASE) into the ordered
//   list of single-frame SPI NOR transactions run by spi_controller: optional
//   WREN, the opcode frame, then RDSR polling until WIP clears or the poll
//   budget runs out. Finishes with a one-cycle rsp_valid carrying rsp_err.
// Parameters
//   POLL_GAP : idle cycles between the end of one RDSR frame and the next start
//   POLL_MAX : RDSR frames allowed per program/erase before a timeout error
// Ports
//   clk, rst : clock, synchronous active-high reset
//   bus      : flash_txn_if.slave (host request/response + spi_controller frame fields)
module flash_txn_sequencer #(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst,
  flash_txn_if.slave  bus
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WREN_GO, S_WREN_WAIT, S_OP_GO, S_OP_WAIT,
    S_POLL_GO, S_POLL_WAIT, S_POLL_GAP, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic        err_q, err_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] poll_inc;

  function automatic logic [7:0] op_code(input logic [1:0] op);
    case (op)
      OP_READ:  op_code = 8'h03;
      OP_PROG:  op_code = 8'h02;
      OP_ERASE: op_code = 8'h20;
      default:  op_code = 8'h00;
    endcase
  endfunction

  // Saturating so a long poll run can never wrap back below POLL_MAX.
  assign poll_inc = (poll_q == POLL_LAST) ? poll_q : poll_q + PW'(1);

  // State and counter registers; the request latch is data and carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      poll_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
    end
    op_q   <= op_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    len_d   = len_q;
    err_d   = err_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // ERASE carries no data, so only READ/PROGRAM reject a zero length.
        if (op_q == 2'b11 || (len_q == 8'd0 && op_q != OP_ERASE)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          err_d   = 1'b0;
          state_d = (op_q == OP_READ) ? S_OP_GO : S_WREN_GO;
        end
      end
      S_WREN_GO:   state_d = S_WREN_WAIT;
      S_WREN_WAIT: if (bus.spi_done) state_d = S_OP_GO;
      S_OP_GO:     state_d = S_OP_WAIT;
      S_OP_WAIT: begin
        if (bus.spi_done) begin
          if (op_q == OP_READ) begin
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            poll_d  = '0;
            state_d = S_POLL_GO;
          end
        end
      end
      S_POLL_GO: state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (bus.spi_done) begin
          poll_d = poll_inc;
          if (!bus.spi_status[0]) begin
            err_d   = 1'b0;
            state_d = S_RESP;
          end else if (poll_inc == POLL_LAST) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            gap_d   = '0;
            state_d = S_POLL_GAP;
          end
        end
      end
      S_POLL_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_POLL_GO;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: frame fields follow the state pair (GO + WAIT), so they are
  // stable from spi_start until the spi_done that closes the frame.
  always_comb begin
    bus.req_ready   = (state_q == S_IDLE);
    bus.busy        = (state_q != S_IDLE);
    bus.rsp_valid   = (state_q == S_RESP);
    bus.rsp_err     = (state_q == S_RESP) && err_q;
    bus.spi_start   = 1'b0;
    bus.spi_opcode  = 8'h00;
    bus.spi_addr    = 24'h0;
    bus.spi_addr_en = 1'b0;
    bus.spi_nbytes  = 8'h00;
    bus.spi_rd      = 1'b0;
    case (state_q)
      S_WREN_GO, S_WREN_WAIT: begin
        bus.spi_start  = (state_q == S_WREN_GO);
        bus.spi_opcode = 8'h06;
      end
      S_OP_GO, S_OP_WAIT: begin
        bus.spi_start   = (state_q == S_OP_GO);
        bus.spi_opcode  = op_code(op_q);
        bus.spi_addr    = addr_q;
        bus.spi_addr_en = 1'b1;
        bus.spi_nbytes  = (op_q == OP_ERASE) ? 8'h00 : len_q;
        bus.spi_rd      = (op_q == OP_READ);
      end
      S_POLL_GO, S_POLL_WAIT: begin
        bus.spi_start  = (state_q == S_POLL_GO);
        bus.spi_opcode = 8'h05;
        bus.spi_nbytes = 8'h01;
        bus.spi_rd     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
